edge_seq_det: RTL and testbench
===============================

# edge_seq_det

Multi-channel, parametrised successor to the single-input four-state sequence FSM. Each channel synchronises and debounces a level input, then tracks the sequence IDLE → START (high) → STOP (low) → CLEAR (high) → IDLE (low). It emits one-cycle pulses at the STOP→CLEAR and CLEAR→IDLE transitions and counts completed sequences. An optional per-state timeout returns a stalled channel to IDLE. The block sits between raw key/strobe pins and control logic that consumes the k1/k2 pulses.

## Interface
- CH, 4, number of independent channels (≥1)
- HOLD, 3, debounce length in cycles; a synchronised level must persist HOLD cycles before acceptance (≥1)
- CNT_W, 8, width of each per-channel completion counter
- TMO, 1000, timeout in cycles of no state change while not in IDLE; counter width is $clog2(TMO+1), derived locally
- sclk  in  1  clock
- s_rst_n  in  1  reset, asynchronous, active-low; clock sclk
- pi_a  in  CH  raw asynchronous level inputs, one per channel
- pi_clr  in  1  synchronous clear of all completion counters
- po_k1  out  CH  1-cycle pulse on CLEAR→IDLE (sequence complete)
- po_k2  out  CH  1-cycle pulse on STOP→CLEAR
- po_err  out  CH  1-cycle pulse on timeout return to IDLE
- po_state  out  4*CH  one-hot current state; channel i is at bits [4i+3:4i]
- po_cnt  out  CH*CNT_W  completed-sequence count; channel i is at bits [CNT_W*i+CNT_W-1:CNT_W*i]

## Operation
- Per-channel path: 2-flop synchroniser, then debounce filter, then FSM, then registered outputs. Channels are fully independent.
- Filter: filt resets to 0. Its counter increments each cycle the synchronised value ≠ filt, and clears whenever they are equal.
  - When the count reaches HOLD, filt takes the synchronised value and the counter clears.
  - Pulses shorter than HOLD cycles at the synchroniser output are rejected.
- State encodings: IDLE=4'b0001, START=4'b0010, STOP=4'b0100, CLEAR=4'b1000.
- FSM transitions, driven by filt:
  - IDLE goes to START when filt=1.
  - START goes to STOP when filt=0.
  - STOP goes to CLEAR when filt=1.
  - CLEAR goes to IDLE when filt=0.
  - Otherwise the FSM holds. Any illegal encoding goes to IDLE without pulses.
- po_k2 asserts in the same cycle the state register becomes CLEAR from STOP.
- po_k1 asserts in the same cycle the state becomes IDLE from CLEAR.
- On each k1 event, po_cnt increments and wraps modulo 2^CNT_W.
- pi_clr zeroes all counters next edge. If pi_clr and a k1 event occur in the same cycle, the counter becomes 0 (clear wins).
- Timeout (see Configuration): the per-channel timer runs in START, STOP and CLEAR, and clears on every state change and in IDLE.
  - When the timer reaches TMO, the next state is IDLE and po_err pulses. No k1/k2 pulse and no count change.
  - If a legal transition and the timeout coincide, the transition wins and the timer clears.
- Reset (including mid-sequence): state=IDLE, filt=0, synchronisers=0, timers=0, po_k1=po_k2=po_err=0, po_state=4'b0001 per channel, po_cnt=0.
  - An input held high through reset release is seen as a fresh rising level and enters START after the filter latency.

## Timing
- Latency from pi_a change to filt change: filt updates on edge E(HOLD+1), where E0 is the first edge sampling the new level.
- The state register updates one edge after filt, at E(HOLD+2). po_k1, po_k2, po_err and po_state are valid from that edge, all registered.
- Minimum accepted level width: HOLD cycles at the synchroniser output.
- Pulses are exactly 1 cycle wide. At most one of k1, k2 and err per channel per cycle.
- po_cnt updates on the same edge as po_k1.

## Configuration
- EDGE_SEQ_TIMEOUT_EN defined: timers present, po_err functional as above.
- EDGE_SEQ_TIMEOUT_EN undefined: no timer logic, po_err tied 0, and non-IDLE states hold indefinitely. TMO is ignored.

## Structure
- Package edge_seq_pkg holds the four one-hot state localparams and the state width constant (4).
- Sub-module edge_seq_filter (synchroniser plus HOLD debounce, parameter HOLD) is instantiated CH times via generate. The FSM, timer and counter stay in the top module.

## Test plan
- CH=4, HOLD=3. Channel 0 runs the pattern high 10 / low 10 / high 10 / low 10 → po_k2 pulse, then po_k1 pulse, po_cnt[0]=1. Channels 1–3 stay IDLE with counts 0.
- Glitch: a 2-cycle high pulse on pi_a[1] → filt unchanged, state stays IDLE, no pulses. A 3-cycle high pulse is accepted and the state becomes START at E5.
- Wrap and clear: run 256 complete sequences on channel 2 with CNT_W=8 → po_cnt[2]=0 with k1 on each. Assert pi_clr in the same cycle as a k1 → count 0.
- Timeout (macro on, TMO=20): enter START and hold high → at 20 cycles in START, po_err pulses once, state becomes IDLE, no k1/k2. With the macro off → remains START.
- Assert s_rst_n low while in CLEAR → all outputs at reset values immediately. After release with pi_a high → START after HOLD+2 edges, no pulses emitted.

Source files
------------

// File: rtl/edge_seq_det_pkg.sv
// edge_seq_pkg
// Shared definitions for the edge_seq_det block: the one-hot state encodings
// of the per-channel sequence FSM and the state vector width.
// No ports (package only).
package edge_seq_pkg;

  localparam int STATE_W = 4;

  localparam logic [STATE_W-1:0] ST_IDLE  = 4'b0001;
  localparam logic [STATE_W-1:0] ST_START = 4'b0010;
  localparam logic [STATE_W-1:0] ST_STOP  = 4'b0100;
  localparam logic [STATE_W-1:0] ST_CLEAR = 4'b1000;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE  = ST_IDLE,
    S_START = ST_START,
    S_STOP  = ST_STOP,
    S_CLEAR = ST_CLEAR
  } state_t;

endpackage

// File: rtl/edge_seq_det_filter.sv
// edge_seq_filter
// Brings one raw asynchronous level into the sclk domain with a 2-flop
// synchroniser, then debounces it: the synchronised level must differ from
// the accepted level for HOLD consecutive cycles before it is accepted.
// Ports:
//   sclk     in  clock
//   s_rst_n  in  asynchronous active-low reset
//   a        in  raw asynchronous level
//   filt     out accepted (debounced) level, resets to 0
module edge_seq_filter #(
  parameter int HOLD = 3
) (
  input  logic sclk,
  input  logic s_rst_n,
  input  logic a,
  output logic filt
);

  // The counter only needs to reach HOLD-1; acceptance happens on the edge
  // that would have taken it to HOLD.
  localparam int CW = (HOLD > 1) ? $clog2(HOLD) : 1;

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  // Synchroniser stages and debounce counter. Any cycle where the synchronised
  // level agrees with filt restarts the count, so short pulses die out.
  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      filt  <= 1'b0;
    end else begin
      sync1 <= a;
      sync2 <= sync1;
      if (sync2 == filt) begin
        cnt <= '0;
      end else if (cnt == CW'(HOLD - 1)) begin
        filt <= sync2;
        cnt  <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/edge_seq_det.sv
// edge_seq_det
// CH independent channels, each: synchroniser + debounce (edge_seq_filter),
// then the IDLE -> START -> STOP -> CLEAR -> IDLE sequence FSM, registered
// pulses and a wrapping completed-sequence counter.
// Optional feature: define EDGE_SEQ_TIMEOUT_EN to add a per-channel stall
// timer that returns a channel to IDLE after TMO cycles without a state change
// outside IDLE (po_err pulses). Without it po_err is tied 0 and TMO is unused.
// Ports:
//   sclk      in  clock
//   s_rst_n   in  asynchronous active-low reset
//   pi_a      in  [CH]         raw level inputs, one per channel
//   pi_clr    in               synchronous clear of all counters (beats k1)
//   po_k1     out [CH]         1-cycle pulse on CLEAR->IDLE
//   po_k2     out [CH]         1-cycle pulse on STOP->CLEAR
//   po_err    out [CH]         1-cycle pulse on timeout return to IDLE
//   po_state  out [4*CH]       one-hot state, channel i at [4i+3:4i]
//   po_cnt    out [CH*CNT_W]   completion count, channel i at [CNT_W*i +: CNT_W]
import edge_seq_pkg::*;

module edge_seq_det #(
  parameter int CH    = 4,
  parameter int HOLD  = 3,
  parameter int CNT_W = 8,
  parameter int TMO   = 1000
) (
  input  logic                  sclk,
  input  logic                  s_rst_n,
  input  logic [CH-1:0]         pi_a,
  input  logic                  pi_clr,
  output logic [CH-1:0]         po_k1,
  output logic [CH-1:0]         po_k2,
  output logic [CH-1:0]         po_err,
  output logic [STATE_W*CH-1:0] po_state,
  output logic [CH*CNT_W-1:0]   po_cnt
);

  for (genvar i = 0; i < CH; i++) begin : g_ch

    logic             filt;
    state_t           state;
    state_t           nxt;
    logic             k1_n;
    logic             k2_n;
    logic             tmo_hit;
    logic             k1_q;
    logic             k2_q;
    logic             err_q;
    logic [CNT_W-1:0] cnt;

    edge_seq_filter #(.HOLD(HOLD)) u_filter (
      .sclk    (sclk),
      .s_rst_n (s_rst_n),
      .a       (pi_a[i]),
      .filt    (filt)
    );

    // Next-state decode; the k1/k2 strobes are computed here so they can be
    // registered on the same edge the state register moves.
    always_comb begin
      nxt  = state;
      k1_n = 1'b0;
      k2_n = 1'b0;
      case (state)
        S_IDLE:  if (filt)  nxt = S_START;
        S_START: if (!filt) nxt = S_STOP;
        S_STOP:  if (filt) begin
                   nxt  = S_CLEAR;
                   k2_n = 1'b1;
                 end
        S_CLEAR: if (!filt) begin
                   nxt  = S_IDLE;
                   k1_n = 1'b1;
                 end
        default: nxt = S_IDLE;
      endcase
    end

`ifdef EDGE_SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TMO + 1);
    logic [TW-1:0] tmr;

    // Fires only while the FSM would otherwise hold, so a legal transition
    // arriving on the same cycle always takes priority.
    assign tmo_hit = (state != S_IDLE) && (nxt == state) && (tmr == TW'(TMO - 1));

    // Stall timer: counts cycles spent in the current non-IDLE state.
    always_ff @(posedge sclk or negedge s_rst_n) begin
      if (!s_rst_n) begin
        tmr <= '0;
      end else if (state == S_IDLE || nxt != state || tmo_hit) begin
        tmr <= '0;
      end else begin
        tmr <= tmr + 1'b1;
      end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    // State register, registered pulses and the completion counter.
    always_ff @(posedge sclk or negedge s_rst_n) begin
      if (!s_rst_n) begin
        state <= S_IDLE;
        k1_q  <= 1'b0;
        k2_q  <= 1'b0;
        err_q <= 1'b0;
        cnt   <= '0;
      end else begin
        state <= tmo_hit ? S_IDLE : nxt;
        k1_q  <= k1_n;
        k2_q  <= k2_n;
        err_q <= tmo_hit;
        if (pi_clr) begin
          cnt <= '0;
        end else if (k1_n) begin
          cnt <= cnt + 1'b1;
        end
      end
    end

    assign po_k1[i]                    = k1_q;
    assign po_k2[i]                    = k2_q;
    assign po_err[i]                   = err_q;
    assign po_state[STATE_W*i +: STATE_W] = state;
    assign po_cnt[CNT_W*i +: CNT_W]    = cnt;

  end

endmodule

// File: tb/tb_edge_seq_det.sv
// tb_edge_seq_det
// Directed bench for edge_seq_det (CH=4, HOLD=3, CNT_W=8, TMO=20). Expected
// values are queued with the cycle at which they must appear; a negedge
// monitor pops and compares them. Handles both EDGE_SEQ_TIMEOUT_EN builds.
module tb_edge_seq_det;

  localparam int CH    = 4;
  localparam int HOLD  = 3;
  localparam int CNT_W = 8;
  localparam int TMO   = 20;
  localparam int LAT   = HOLD + 3;

  localparam int K_K1  = 0;
  localparam int K_K2  = 1;
  localparam int K_ERR = 2;
  localparam int K_ST  = 3;
  localparam int K_CNT = 4;
  localparam int T_K1  = 5;
  localparam int T_K2  = 6;
  localparam int T_ERR = 7;

  typedef struct {
    int    cyc;
    string tag;
    int    kind;
    int    ch;
    int    val;
  } exp_t;

  logic                sclk = 1'b0;
  logic                s_rst_n = 1'b0;
  logic [CH-1:0]       pi_a = '0;
  logic                pi_clr = 1'b0;
  logic [CH-1:0]       po_k1;
  logic [CH-1:0]       po_k2;
  logic [CH-1:0]       po_err;
  logic [4*CH-1:0]     po_state;
  logic [CH*CNT_W-1:0] po_cnt;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   k1_t[CH];
  int   k2_t[CH];
  int   err_t[CH];
  exp_t sb[$];

  edge_seq_det #(.CH(CH), .HOLD(HOLD), .CNT_W(CNT_W), .TMO(TMO)) dut (
    .sclk     (sclk),
    .s_rst_n  (s_rst_n),
    .pi_a     (pi_a),
    .pi_clr   (pi_clr),
    .po_k1    (po_k1),
    .po_k2    (po_k2),
    .po_err   (po_err),
    .po_state (po_state),
    .po_cnt   (po_cnt)
  );

  always #5 sclk = ~sclk;

  always @(posedge sclk) cyc = cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] observe(input int kind, input int ch);
    case (kind)
      K_K1:    return 32'(po_k1[ch]);
      K_K2:    return 32'(po_k2[ch]);
      K_ERR:   return 32'(po_err[ch]);
      K_ST:    return 32'(po_state[4*ch +: 4]);
      K_CNT:   return 32'(po_cnt[CNT_W*ch +: CNT_W]);
      T_K1:    return k1_t[ch];
      T_K2:    return k2_t[ch];
      default: return err_t[ch];
    endcase
  endfunction

  // Tally pulses each cycle, then compare everything due at this cycle.
  always @(negedge sclk) begin
    exp_t e;
    for (int i = 0; i < CH; i++) begin
      k1_t[i]  += int'(po_k1[i]);
      k2_t[i]  += int'(po_k2[i]);
      err_t[i] += int'(po_err[i]);
    end
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      if (e.cyc < cyc) checkOutput({e.tag, "_late"}, cyc, e.cyc);
      else             checkOutput(e.tag, observe(e.kind, e.ch), e.val);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge sclk);
    #1;
  endtask

  task automatic expectAt(input int c, input string tag, input int kind, input int ch, input int val);
    sb.push_back('{c, tag, kind, ch, val});
  endtask

  task automatic applyStimulus(input int ch, input logic level, output int t0);
    pi_a[ch] = level;
    t0 = cyc;
  endtask

  task automatic clearTallies();
    for (int i = 0; i < CH; i++) begin
      k1_t[i]  = 0;
      k2_t[i]  = 0;
      err_t[i] = 0;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && sb.size() > 0; i++) tick(1);
    checkOutput("sb_drain", sb.size(), 0);
    clearTallies();
  endtask

  // Three phases of a sequence with width w; the final falling drive is made
  // and the cycle at which k1 must appear is returned.
  task automatic runSeq(input int ch, input int w, output int tk);
    int t;
    applyStimulus(ch, 1'b1, t);
    tick(w);
    applyStimulus(ch, 1'b0, t);
    tick(w);
    applyStimulus(ch, 1'b1, t);
    tick(w);
    applyStimulus(ch, 1'b0, t);
    tk = t + LAT;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int t;
    int t2;
    int tk;
    clearTallies();

    // Reset values while reset is held
    tick(2);
    checkOutput("rst_state", po_state, 32'h1111);
    checkOutput("rst_k1", po_k1, 0);
    checkOutput("rst_k2", po_k2, 0);
    checkOutput("rst_err", po_err, 0);
    checkOutput("rst_cnt", po_cnt, 0);
    s_rst_n = 1'b1;
    tick(2);
    drain();

    // Full sequence on channel 0
    $display("[TB] full sequence on ch0");
    applyStimulus(0, 1'b1, t);
    expectAt(t + LAT - 1, "t1_pre_start", K_ST, 0, 1);
    expectAt(t + LAT, "t1_start", K_ST, 0, 2);
    tick(10);
    applyStimulus(0, 1'b0, t);
    expectAt(t + LAT, "t1_stop", K_ST, 0, 4);
    tick(10);
    applyStimulus(0, 1'b1, t);
    expectAt(t + LAT - 1, "t1_k2_pre", K_K2, 0, 0);
    expectAt(t + LAT, "t1_k2", K_K2, 0, 1);
    expectAt(t + LAT, "t1_clear", K_ST, 0, 8);
    expectAt(t + LAT + 1, "t1_k2_post", K_K2, 0, 0);
    tick(10);
    applyStimulus(0, 1'b0, t);
    expectAt(t + LAT - 1, "t1_cnt_pre", K_CNT, 0, 0);
    expectAt(t + LAT, "t1_k1", K_K1, 0, 1);
    expectAt(t + LAT, "t1_cnt", K_CNT, 0, 1);
    expectAt(t + LAT, "t1_idle", K_ST, 0, 1);
    expectAt(t + LAT + 1, "t1_k1_post", K_K1, 0, 0);
    tick(10);
    expectAt(cyc + 1, "t1_k1_tally", T_K1, 0, 1);
    expectAt(cyc + 1, "t1_k2_tally", T_K2, 0, 1);
    for (int i = 1; i < CH; i++) begin
      expectAt(cyc + 1, $sformatf("t1_idle_ch%0d", i), K_ST, i, 1);
      expectAt(cyc + 1, $sformatf("t1_cnt_ch%0d", i), K_CNT, i, 0);
      expectAt(cyc + 1, $sformatf("t1_k1t_ch%0d", i), T_K1, i, 0);
    end
    drain();

    // Glitch rejection and minimum accepted width on channel 1
    $display("[TB] glitch on ch1");
    applyStimulus(1, 1'b1, t);
    tick(2);
    applyStimulus(1, 1'b0, t2);
    expectAt(t + LAT, "glitch_idle", K_ST, 1, 1);
    expectAt(t + LAT + 3, "glitch_idle_late", K_ST, 1, 1);
    tick(12);
    expectAt(cyc + 1, "glitch_k1t", T_K1, 1, 0);
    expectAt(cyc + 1, "glitch_k2t", T_K2, 1, 0);
    drain();
    applyStimulus(1, 1'b1, t);
    expectAt(t + LAT - 1, "hold3_pre", K_ST, 1, 1);
    expectAt(t + LAT, "hold3_start", K_ST, 1, 2);
    tick(3);
    applyStimulus(1, 1'b0, t2);
    expectAt(t2 + LAT, "hold3_stop", K_ST, 1, 4);
    tick(10);
    applyStimulus(1, 1'b1, t);
    expectAt(t + LAT, "hold3_clear", K_ST, 1, 8);
    tick(10);
    applyStimulus(1, 1'b0, t);
    expectAt(t + LAT, "hold3_cnt", K_CNT, 1, 1);
    tick(10);
    drain();

    // 256 sequences on channel 2: count wraps to 0
    $display("[TB] wrap on ch2");
    for (int n = 0; n < 256; n++) begin
      runSeq(2, 5, tk);
      expectAt(tk, "wrap_k1", K_K1, 2, 1);
      expectAt(tk, "wrap_cnt", K_CNT, 2, (n + 1) % 256);
      tick(5);
    end
    expectAt(cyc + 1, "wrap_k1_tally", T_K1, 2, 256);
    expectAt(cyc + 1, "wrap_cnt_final", K_CNT, 2, 0);
    drain();

    // pi_clr coinciding with a k1 event: clear wins, all counters zeroed
    $display("[TB] clear vs k1");
    runSeq(2, 5, tk);
    expectAt(tk - 1, "clr_ch0_before", K_CNT, 0, 1);
    expectAt(tk, "clr_k1", K_K1, 2, 1);
    expectAt(tk, "clr_cnt_ch2", K_CNT, 2, 0);
    expectAt(tk, "clr_cnt_ch0", K_CNT, 0, 0);
    expectAt(tk, "clr_cnt_ch1", K_CNT, 1, 0);
    expectAt(tk + 1, "clr_cnt_ch2_after", K_CNT, 2, 0);
    tick(5);
    pi_clr = 1'b1;
    tick(1);
    pi_clr = 1'b0;
    tick(5);
    drain();

    // Stall in START/STOP on channel 3
    $display("[TB] timeout on ch3");
    applyStimulus(3, 1'b1, t);
    expectAt(t + LAT, "tmo_start", K_ST, 3, 2);
`ifdef EDGE_SEQ_TIMEOUT_EN
    expectAt(t + LAT + 19, "tmo_err_pre", K_ERR, 3, 0);
    expectAt(t + LAT + 20, "tmo_err", K_ERR, 3, 1);
    expectAt(t + LAT + 20, "tmo_idle", K_ST, 3, 1);
    expectAt(t + LAT + 21, "tmo_err_post", K_ERR, 3, 0);
    expectAt(t + LAT + 21, "tmo_restart", K_ST, 3, 2);
`else
    expectAt(t + LAT + 20, "tmo_hold", K_ST, 3, 2);
    expectAt(t + LAT + 20, "tmo_no_err", K_ERR, 3, 0);
    expectAt(t + LAT + 21, "tmo_hold2", K_ST, 3, 2);
`endif
    tick(28);
    applyStimulus(3, 1'b0, t2);
    expectAt(t2 + LAT, "tmo_stop", K_ST, 3, 4);
`ifdef EDGE_SEQ_TIMEOUT_EN
    expectAt(t2 + LAT + 20, "tmo_err2", K_ERR, 3, 1);
    expectAt(t2 + LAT + 20, "tmo_idle2", K_ST, 3, 1);
`else
    expectAt(t2 + LAT + 20, "tmo_stop_hold", K_ST, 3, 4);
`endif
    tick(30);
`ifdef EDGE_SEQ_TIMEOUT_EN
    expectAt(cyc + 1, "tmo_err_tally", T_ERR, 3, 2);
`else
    expectAt(cyc + 1, "tmo_err_tally", T_ERR, 3, 0);
`endif
    expectAt(cyc + 1, "tmo_k1_tally", T_K1, 3, 0);
    expectAt(cyc + 1, "tmo_k2_tally", T_K2, 3, 0);
    drain();

    // Reset while channel 0 sits in CLEAR, input held high through release
    $display("[TB] reset in CLEAR");
    runSeq(0, 10, tk);
    expectAt(tk, "rc_cnt", K_CNT, 0, 1);
    tick(10);
    applyStimulus(0, 1'b1, t);
    tick(10);
    applyStimulus(0, 1'b0, t);
    tick(10);
    applyStimulus(0, 1'b1, t);
    expectAt(t + LAT, "rc_clear", K_ST, 0, 8);
    tick(10);
    drain();
    s_rst_n = 1'b0;
    #2;
    checkOutput("rc_rst_state", po_state, 32'h1111);
    checkOutput("rc_rst_cnt", po_cnt, 0);
    checkOutput("rc_rst_k1", po_k1, 0);
    checkOutput("rc_rst_k2", po_k2, 0);
    checkOutput("rc_rst_err", po_err, 0);
    tick(3);
    clearTallies();
    s_rst_n = 1'b1;
    t = cyc;
    expectAt(t + LAT - 1, "rc_rel_idle", K_ST, 0, 1);
    expectAt(t + LAT, "rc_rel_start", K_ST, 0, 2);
    tick(15);
    expectAt(cyc + 1, "rc_k1_tally", T_K1, 0, 0);
    expectAt(cyc + 1, "rc_k2_tally", T_K2, 0, 0);
    expectAt(cyc + 1, "rc_err_tally", T_ERR, 0, 0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
